// File: rtl/divider_16x8_seq_pkg.sv
// Shared widths, iteration-count width and FSM encoding for the sequential 16/8 divider.
// Imported by the interface, the step datapath and the top.
package div_pkg;
    localparam int DIVIDEND_W = 16;
    localparam int DIVISOR_W  = 8;
    localparam int CNT_W      = $clog2(DIVIDEND_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/divider_16x8_seq_if.sv
// Start/done handshake plus operand and result buses between a controller and the divider.
// The controller holds the master side; the divider holds the slave side.
interface divider_16x8_seq_if;
    import div_pkg::*;

    logic                  start;
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
    logic                  ready;
    logic                  busy;
    logic                  done;
    logic [DIVIDEND_W-1:0] quotient;
    logic [DIVISOR_W-1:0]  remainder;
    logic                  div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  ready, busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output ready, busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/divider_16x8_seq_step.sv
// One restoring-division iteration: shift in the next dividend bit, subtract the divisor if it fits.
// Purely combinational; the partial remainder stays below the divisor, so only the shifted value needs the extra bit.
module div_step
    import div_pkg::*;
(
    input  logic [DIVISOR_W-1:0] prem,
    input  logic                 dvd_bit,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W-1:0] prem_nxt,
    output logic                 q_bit
);
    logic [DIVISOR_W:0] shifted;

    always_comb begin
        shifted  = {prem, dvd_bit};
        q_bit    = (shifted >= {1'b0, divisor});
        prem_nxt = q_bit ? DIVISOR_W'(shifted - {1'b0, divisor}) : shifted[DIVISOR_W-1:0];
    end
endmodule

// File: rtl/divider_16x8_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock; done 17 edges after the accepting edge (1 for divide-by-zero).
// Backpressure: ready drops from the accepting edge until done; start while not ready is ignored.
module divider_16x8_seq
    import div_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    divider_16x8_seq_if.slave   bus
);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIVIDEND_W - 1);

    state_t                state, state_nxt;
    logic                  pend;
    logic [DIVIDEND_W-1:0] dvd_sh;
    logic [DIVISOR_W-1:0]  dvs_q;
    logic [DIVIDEND_W-1:0] quo_sh;
    logic [DIVISOR_W-1:0]  prem;
    logic [CNT_W-1:0]      cnt;
    logic [DIVIDEND_W-1:0] quotient_q;
    logic [DIVISOR_W-1:0]  remainder_q;
    logic                  dz_q;

    logic [DIVISOR_W-1:0]  prem_nxt;
    logic                  q_bit;
    logic                  accept;

    div_step u_step (
        .prem     (prem),
        .dvd_bit  (dvd_sh[DIVIDEND_W-1]),
        .divisor  (dvs_q),
        .prem_nxt (prem_nxt),
        .q_bit    (q_bit)
    );

    // Operands land in a capture stage first; the FSM launches from it on the following edge.
    assign bus.ready       = (state != RUN) && !pend;
    assign bus.busy        = (state == RUN);
    assign bus.done        = (state == DONE);
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dz_q;
    assign accept          = bus.start && bus.ready;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pend) state_nxt = (dvs_q == '0) ? DONE : RUN;
            RUN:     if (cnt == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pend        <= 1'b0;
            dvd_sh      <= '0;
            dvs_q       <= '0;
            quo_sh      <= '0;
            prem        <= '0;
            cnt         <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dz_q        <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                pend   <= 1'b1;
                dvd_sh <= bus.dividend;
                dvs_q  <= bus.divisor;
            end else if (state == IDLE && pend) begin
                pend <= 1'b0;
                prem <= '0;
                cnt  <= CNT_LOAD;
                if (dvs_q == '0) begin
                    quotient_q  <= '1;
                    remainder_q <= '1;
                    dz_q        <= 1'b1;
                end
            end else if (state == RUN) begin
                dvd_sh <= {dvd_sh[DIVIDEND_W-2:0], 1'b0};
                quo_sh <= {quo_sh[DIVIDEND_W-2:0], q_bit};
                prem   <= prem_nxt;
                cnt    <= cnt - 1'b1;
                if (cnt == '0) begin
                    quotient_q  <= {quo_sh[DIVIDEND_W-2:0], q_bit};
                    remainder_q <= prem_nxt;
                    dz_q        <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_divider_16x8_seq.sv
// Scoreboarded bench for divider_16x8_seq: directed cases, mid-run reset, ignored start, back-to-back and a random sweep.
module tb_divider_16x8_seq;
    import div_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    divider_16x8_seq_if bus();

    divider_16x8_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt++;

    typedef struct {
        int dvd;
        int dvs;
        int edge_n;
    } txn_t;

    txn_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(string nm, longint act, longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Reference model: plain integer division, all-ones results for a zero divisor.
    txn_t t;
    int   eq, er, ez, lat;
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1, expected no result pending");
            end else begin
                t = exp_q.pop_front();
                if (t.dvs == 0) begin
                    eq = 65535; er = 255; ez = 1; lat = 1;
                end else begin
                    eq = t.dvd / t.dvs; er = t.dvd % t.dvs; ez = 0; lat = DIVIDEND_W + 1;
                end
                chk("quotient", bus.quotient, eq);
                chk("remainder", bus.remainder, er);
                chk("div_by_zero", bus.div_by_zero, ez);
                chk("latency", edge_cnt - t.edge_n, lat);
                if (t.dvs != 0) begin
                    chk("identity", int'(bus.quotient) * t.dvs + int'(bus.remainder), t.dvd);
                    chk("rem_lt_div", (int'(bus.remainder) < t.dvs) ? 1 : 0, 1);
                end
            end
        end
    end

    task automatic issue(input int dvd, input int dvs, output int e);
        int w = 0;
        @(negedge clk);
        while (!bus.ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!bus.ready) begin
            chk("ready_timeout", 0, 1);
            e = -1;
        end else begin
            bus.start    = 1'b1;
            bus.dividend = 16'(dvd);
            bus.divisor  = 8'(dvs);
            @(posedge clk);
            #1;
            e = edge_cnt;
            exp_q.push_back('{dvd, dvs, e});
            @(negedge clk);
            bus.start    = 1'b0;
            bus.dividend = 16'($urandom);
            bus.divisor  = 8'($urandom);
        end
    endtask

    task automatic wait_idle();
        int w = 0;
        while (exp_q.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (exp_q.size() != 0) begin
            chk("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    int e, e1, e2;
    int dir_dvd[4] = '{65535, 36, 5, 1234};
    int dir_dvs[4] = '{255, 3, 20, 0};

    initial begin
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        #12;
        chk("rst_ready", bus.ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_quotient", bus.quotient, 0);
        chk("rst_remainder", bus.remainder, 0);
        chk("rst_dz", bus.div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1000/7 with busy window
        issue(1000, 7, e);
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            chk($sformatf("busy_after_edge_%0d", k), bus.busy, (k <= 16) ? 1 : 0);
        end
        wait_idle();

        for (int i = 0; i < 4; i++) begin
            issue(dir_dvd[i], dir_dvs[i], e);
            wait_idle();
        end

        // start while busy must be ignored
        issue(1000, 7, e);
        repeat (4) @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 16'd50;
        bus.divisor  = 8'd5;
        chk("ready_while_busy", bus.ready, 0);
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle();

        // back-to-back: second start lands in the done cycle of the first
        issue(1000, 7, e1);
        issue(100, 9, e2);
        chk("b2b_accept_edge", e2 - e1, DIVIDEND_W + 2);
        chk("held_quotient", bus.quotient, 142);
        wait_idle();

        // asynchronous reset at edge 8 of an operation
        issue(1000, 7, e);
        repeat (7) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", bus.ready, 1);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_done", bus.done, 0);
        chk("mid_rst_quotient", bus.quotient, 0);
        chk("mid_rst_remainder", bus.remainder, 0);
        chk("mid_rst_dz", bus.div_by_zero, 0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        issue(65535, 1, e);
        wait_idle();

        for (int i = 0; i < 1000; i++) begin
            issue(int'($urandom_range(0, 65535)), int'($urandom_range(1, 255)), e);
        end
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
